// File: rtl/sync_debounce_edge.sv
// Multi-channel input conditioner: synchroniser chain, tick-driven debounce
// filter and registered one-cycle rise/fall pulses per channel.
module sync_debounce_edge #(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SAMPLE_CNT_MAX = 25000,
  parameter int unsigned PULSE_CNT_MAX  = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int unsigned SCW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int unsigned FCW = $clog2(PULSE_CNT_MAX + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SCW-1:0]                    samp_cnt_q;
  logic                              tick_c;
  logic [WIDTH-1:0][FCW-1:0]         fcnt_q;
  logic [WIDTH-1:0][FCW-1:0]         fcnt_d;
  logic [WIDTH-1:0]                  level_d;
  logic [WIDTH-1:0]                  rise_d;
  logic [WIDTH-1:0]                  fall_d;

  // Plain shift chain; nothing between stages so each stage can resolve metastability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shared sample tick, one cycle per SAMPLE_CNT_MAX clocks
  assign tick_c = (samp_cnt_q == SCW'(SAMPLE_CNT_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         samp_cnt_q <= '0;
    else if (tick_c) samp_cnt_q <= '0;
    else             samp_cnt_q <= samp_cnt_q + SCW'(1);
  end

  // Per-channel filter: level follows sync_out after PULSE_CNT_MAX consecutive mismatching ticks
  always_comb begin
    fcnt_d  = fcnt_q;
    level_d = level_out;
    rise_d  = '0;
    fall_d  = '0;
    if (tick_c) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync_out[i] == level_out[i]) begin
          fcnt_d[i] = '0;
        end else if (fcnt_q[i] == FCW'(PULSE_CNT_MAX - 1)) begin
          fcnt_d[i]  = '0;
          level_d[i] = sync_out[i];
          rise_d[i]  = sync_out[i];
          fall_d[i]  = ~sync_out[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + FCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q     <= '0;
      level_out  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      fcnt_q     <= fcnt_d;
      level_out  <= level_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Bench for sync_debounce_edge: two configurations driven in parallel and
// compared every cycle against an edge-indexed behavioural model.
module tb_sync_debounce_edge;

  localparam int P = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] async_in;
  logic [1:0] s0, l0, r0, f0;
  logic [1:0] s1, l1, r1, f1;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  // Model state: every input sampled since reset, plus per-config level/run/pulses
  logic [1:0] samp_q[$];
  int         n_edges;
  logic [1:0] m_lvl  [2];
  logic [1:0] m_rise [2];
  logic [1:0] m_fall [2];
  int         m_run  [2][2];

  sync_debounce_edge #(
    .WIDTH(2), .SYNC_STAGES(3), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3)
  ) dut0 (
    .clk(clk), .rst(rst), .async_in(async_in),
    .sync_out(s0), .level_out(l0), .rise_pulse(r0), .fall_pulse(f0)
  );

  sync_debounce_edge #(
    .WIDTH(2), .SYNC_STAGES(2), .SAMPLE_CNT_MAX(1), .PULSE_CNT_MAX(3)
  ) dut1 (
    .clk(clk), .rst(rst), .async_in(async_in),
    .sync_out(s1), .level_out(l1), .rise_pulse(r1), .fall_pulse(f1)
  );

  initial forever #5 clk = ~clk;

  function automatic int s_of(input int c);
    return (c == 0) ? 3 : 2;
  endfunction

  function automatic int m_of(input int c);
    return (c == 0) ? 4 : 1;
  endfunction

  // sync_out after edge k is the input sampled at edge k-S+1 (zero before that)
  function automatic logic [1:0] sync_at(input int c, input int k);
    int idx;
    idx = k - s_of(c) + 1;
    if (idx >= 1) return samp_q[idx-1];
    return 2'b00;
  endfunction

  task automatic model_reset();
    samp_q.delete();
    n_edges = 0;
    for (int c = 0; c < 2; c++) begin
      m_lvl[c]  = 2'b00;
      m_rise[c] = 2'b00;
      m_fall[c] = 2'b00;
      for (int ch = 0; ch < 2; ch++) m_run[c][ch] = 0;
    end
  endtask

  // Edge n is a sample tick when n is a multiple of the period
  task automatic model_edge();
    logic [1:0] s;
    n_edges++;
    for (int c = 0; c < 2; c++) begin
      m_rise[c] = 2'b00;
      m_fall[c] = 2'b00;
      if (n_edges % m_of(c) == 0) begin
        s = sync_at(c, n_edges - 1);
        for (int ch = 0; ch < 2; ch++) begin
          if (s[ch] != m_lvl[c][ch]) begin
            m_run[c][ch]++;
            if (m_run[c][ch] == P) begin
              m_run[c][ch]  = 0;
              m_lvl[c][ch]  = s[ch];
              m_rise[c][ch] = s[ch];
              m_fall[c][ch] = ~s[ch];
            end
          end else begin
            m_run[c][ch] = 0;
          end
        end
      end
    end
    samp_q.push_back(async_in);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/d0.sync"},  8'(s0), 8'(sync_at(0, n_edges)));
    chk({tag, "/d0.level"}, 8'(l0), 8'(m_lvl[0]));
    chk({tag, "/d0.rise"},  8'(r0), 8'(m_rise[0]));
    chk({tag, "/d0.fall"},  8'(f0), 8'(m_fall[0]));
    chk({tag, "/d1.sync"},  8'(s1), 8'(sync_at(1, n_edges)));
    chk({tag, "/d1.level"}, 8'(l1), 8'(m_lvl[1]));
    chk({tag, "/d1.rise"},  8'(r1), 8'(m_rise[1]));
    chk({tag, "/d1.fall"},  8'(f1), 8'(m_fall[1]));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int cnt_a, cnt_b, cnt_c;
    bit reached;

    // Case 1: reset, then latency of the synchroniser
    rst      = 1'b1;
    async_in = 2'b00;
    model_reset();
    step("rst_a");
    step("rst_b");
    rst = 1'b0;
    step("rel");
    async_in[0] = 1'b1;
    step("c1_e1");
    chk("c1_lat_e1", 8'(s0[0]), 8'd0);
    step("c1_e2");
    chk("c1_lat_e2", 8'(s0[0]), 8'd0);
    step("c1_e3");
    chk("c1_lat_e3", 8'(s0[0]), 8'd1);
    chk("c1_level",  8'(l0),    8'd0);

    // Case 2: clean press
    cnt_a = 0;
    for (int k = 0; k < 40; k++) begin
      step("c2");
      if (r0[0]) begin
        cnt_a++;
        chk("c2_coinc", 8'(l0[0]), 8'd1);
      end
    end
    chk("c2_rise_cnt", 8'(cnt_a), 8'd1);
    chk("c2_level",    8'(l0),    8'd1);

    // Case 4: release
    async_in[0] = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 40; k++) begin
      step("c4");
      if (f0[0]) cnt_a++;
      if (r0[0]) cnt_b++;
    end
    chk("c4_fall_cnt", 8'(cnt_a), 8'd1);
    chk("c4_rise_cnt", 8'(cnt_b), 8'd0);
    chk("c4_level",    8'(l0),    8'd0);

    // Case 3: two mismatching ticks, one agreeing tick, then a steady press
    cnt_a = 0;
    async_in[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step("c3_hi");
      if (r0[0]) cnt_a++;
    end
    async_in[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step("c3_lo");
      if (r0[0]) cnt_a++;
    end
    step("c3_mid");
    if (r0[0]) cnt_a++;
    chk("c3_no_flip", 8'(l0[0]), 8'd0);
    async_in[0] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step("c3_hold");
      if (r0[0]) cnt_a++;
    end
    chk("c3_rise_cnt", 8'(cnt_a), 8'd1);
    async_in[0] = 1'b0;
    for (int k = 0; k < 40; k++) step("c3_back");

    // Case 5: both channels change together
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    async_in = 2'b11;
    for (int k = 0; k < 40; k++) begin
      step("c5_up");
      if (r0 == 2'b11) cnt_a++;
      if (r0 == 2'b01 || r0 == 2'b10) cnt_b++;
    end
    async_in = 2'b00;
    for (int k = 0; k < 40; k++) begin
      step("c5_dn");
      if (f0 == 2'b11) cnt_c++;
      if (f0 == 2'b01 || f0 == 2'b10) cnt_b++;
    end
    chk("c5_rise_both", 8'(cnt_a), 8'd1);
    chk("c5_fall_both", 8'(cnt_c), 8'd1);
    chk("c5_split",     8'(cnt_b), 8'd0);

    // Case 6: reset after two mismatching ticks
    async_in = 2'b01;
    reached  = 1'b0;
    for (int k = 0; k < 40 && !reached; k++) begin
      step("c6_pre");
      if (m_run[0][0] == 2) reached = 1'b1;
    end
    chk("c6_bound",    8'(reached), 8'd1);
    chk("c6_pre_lvl",  8'(l0[0]),   8'd0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("c6_async_l1", 8'(l1), 8'd0);
    chk("c6_async_s0", 8'(s0), 8'd0);
    check_all("c6_async");
    step("c6_rst");
    rst = 1'b0;
    cnt_a = 0;
    for (int k = 0; k < 40; k++) begin
      step("c6_post");
      if (r0[0]) cnt_a++;
    end
    chk("c6_rise_cnt", 8'(cnt_a), 8'd1);

    // Random toggling with occasional asynchronous resets
    for (int k = 0; k < 500; k++) begin
      for (int ch = 0; ch < 2; ch++)
        if ($urandom_range(0, 15) == 0) async_in[ch] = ~async_in[ch];
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rnd_rst");
        step("rnd_rsth");
        rst = 1'b0;
      end
      step("rnd");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
